qspi_ram_responder: RTL
=======================

QSPI_RAM_RESPONDER -- requirements
Module: qspi_ram_responder

Interface
REQ-001 SHALL have parameter DUMMY_CYCLES, default 6, setting the number of ram_clk cycles between address and read data; legal range 1..15.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, setting the synchronizer depth on in_ram_csn, in_ram_clk and in_ram_io.
REQ-003 clock  in  1  system clock; one clock domain; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_ram_csn  in  1  chip select from the initiator, active low.
REQ-006 in_ram_clk  in  1  QSPI clock from the initiator; oversampled, not used as a clock.
REQ-007 in_ram_io  in  4  QSPI data lines as seen by the responder.
REQ-008 out_ram_io  out  4  nibble the responder drives during read data.
REQ-009 out_ram_io_oe  out  4  output enables for out_ram_io, active high.
REQ-010 mem_addr  out  24  byte address to the backing store.
REQ-011 mem_wdata  out  8  write byte to the backing store.
REQ-012 mem_wr  out  1  single-cycle write strobe.
REQ-013 mem_rd  out  1  single-cycle read strobe.
REQ-014 mem_rdata  in  8  read byte; valid exactly 1 clock after mem_rd.

Function
REQ-015 SHALL sample csn, clk and io through SYNC_STAGES flops, then detect ram_clk rising and falling edges by comparing against the previous synchronized value.
REQ-016 SHALL be correct only when the clock frequency is at least 4x the ram_clk frequency.
REQ-017 All phases SHALL use quad (QPI) mode, high nibble first: 2 command nibbles, then 6 address nibbles (MSB first), each sampled on a ram_clk rising edge.
REQ-018 State machine: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-019 Transitions:
- IDLE->CMD on synchronized csn falling.
- CMD->ADDR after 2 nibbles if the command is 0xEB (read) or 0x38 (write).
- CMD->IGNORE for any other command.
- ADDR->DUMMY (read) or ADDR->WDATA (write) after 6 nibbles.
- DUMMY->RDATA after DUMMY_CYCLES rising edges.
REQ-020 Any state SHALL return to IDLE within 1 clock of synchronized csn high; this has priority over every other event in the same cycle.
REQ-021 Read:
- mem_rd pulses with mem_addr = captured address on the clock after the last address nibble is sampled.
- The first data nibble (high) is driven on the ram_clk falling edge that follows the last dummy rising edge.
- Each subsequent falling edge drives the next nibble.
REQ-022 Read: after driving the low nibble of byte N, the responder SHALL increment the address and pulse mem_rd for byte N+1 on the next clock (prefetch).
REQ-023 out_ram_io_oe SHALL be 4'hF only in RDATA and 4'h0 otherwise; out_ram_io SHALL be 0 whenever oe is 0.
REQ-024 Write: bytes are assembled from nibble pairs; on the clock after the low nibble is sampled, mem_wr pulses with mem_addr and mem_wdata, then the address increments.
REQ-025 Address SHALL increment modulo 2^24 (0xFFFFFF wraps to 0x000000).
REQ-026 A partially received write byte (odd nibble count) at csn rise SHALL be discarded with no mem_wr.
REQ-027 A csn rise during ADDR or DUMMY SHALL produce no mem_wr and no further mem_rd.
REQ-028 mem_wr and mem_rd SHALL never be high in the same cycle.
REQ-029 In IGNORE, ram_clk edges SHALL be ignored until csn rises.

Reset
REQ-030 On reset: state IDLE, out_ram_io = 0, out_ram_io_oe = 0, mem_wr = 0, mem_rd = 0, mem_addr = 0, mem_wdata = 0, synchronizers cleared with csn synchronized high.
REQ-031 Reset asserted mid-transaction SHALL abort it; a new transaction is only recognized after csn has been seen high and then low.

Verification
REQ-032 Write 0x38, addr 0x000010, data A5 3C, csn high -> mem_wr pulses twice: (0x000010, 0xA5), (0x000011, 0x3C).
REQ-033 Read 0xEB, addr 0x000100, 6 dummy cycles, backing store 0x12 0x34 -> mem_rd at 0x100, then 0x101; io shows nibbles 1,2,3,4 on consecutive falling edges; oe = F only in the data phase.
REQ-034 Write at 0xFFFFFF, 2 bytes -> second mem_wr address is 0x000000.
REQ-035 Write of 3 nibbles then csn high -> exactly 1 mem_wr; state IDLE; oe 0.
REQ-036 Command 0x9F plus 10 clocks -> no mem_rd, no mem_wr, oe stays 0; the next 0xEB transaction works normally.
REQ-037 Reset pulse during read data phase -> all outputs 0 next clock; a following read transaction returns correct data.

Source files
------------

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: oversampled QPI responder that bridges 0xEB reads / 0x38 writes to a byte-wide backing store.
module qspi_ram_responder #(
  parameter int DUMMY_CYCLES = 6,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_ram_csn,
  input  logic        in_ram_clk,
  input  logic [3:0]  in_ram_io,
  output logic [3:0]  out_ram_io,
  output logic [3:0]  out_ram_io_oe,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d, clk_sync_q, clk_sync_d, vld_q, vld_d;
  logic [3:0] io_sync_q [SYNC_STAGES];
  logic [3:0] io_sync_d [SYNC_STAGES];
  logic csn_prev_q, csn_prev_d, clk_prev_q, clk_prev_d;
  logic [3:0] cnt_q, cnt_d, cmd_q, cmd_d, wbuf_q, wbuf_d, io_q, io_d;
  logic [23:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic is_rd_q, is_rd_d, hi_q, hi_d, mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d, rd_dly_q, rd_dly_d;
  logic csn_s, clk_s, rise, fall, csn_fall;
  logic [3:0] io_s;
  logic [7:0] cmd_w;
  logic [23:0] addr_w;
  assign csn_s = csn_sync_q[SYNC_STAGES-1];
  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign io_s = io_sync_q[SYNC_STAGES-1];
  assign rise = clk_s & ~clk_prev_q;
  assign fall = ~clk_s & clk_prev_q;
  // csn_prev_q only goes high once real (post-reset) samples show csn high
  assign csn_fall = csn_prev_q & ~csn_s;
  assign cmd_w = {cmd_q, io_s};
  assign addr_w = {addr_q[19:0], io_s};
  assign out_ram_io_oe = (state_q == RDATA) ? 4'hF : 4'h0;
  assign out_ram_io = io_q & out_ram_io_oe;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr = mem_wr_q;
  assign mem_rd = mem_rd_q;
  always_comb begin
    csn_sync_d[0] = in_ram_csn;
    clk_sync_d[0] = in_ram_clk;
    io_sync_d[0] = in_ram_io;
    vld_d[0] = 1'b1;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      csn_sync_d[i] = csn_sync_q[i-1];
      clk_sync_d[i] = clk_sync_q[i-1];
      io_sync_d[i] = io_sync_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
    csn_prev_d = csn_s & vld_q[SYNC_STAGES-1];
    clk_prev_d = clk_s;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    is_rd_d = is_rd_q;
    hi_d = hi_q;
    wbuf_d = wbuf_q;
    io_d = (state_q == RDATA) ? io_q : 4'h0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d = 1'b0;
    mem_rd_d = 1'b0;
    rd_dly_d = mem_rd_q;
    rdata_d = rd_dly_q ? mem_rdata : rdata_q;
    if (csn_s) state_d = IDLE;
    else case (state_q)
      IDLE: if (csn_fall) begin
        state_d = CMD;
        cnt_d = 4'd0;
      end
      CMD: if (rise) begin
        cmd_d = io_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd1) begin
          cnt_d = 4'd0;
          is_rd_d = cmd_w == 8'hEB;
          state_d = (cmd_w == 8'hEB || cmd_w == 8'h38) ? ADDR : IGNORE;
        end
      end
      ADDR: if (rise) begin
        addr_d = addr_w;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd5) begin
          cnt_d = 4'd0;
          hi_d = 1'b1;
          state_d = is_rd_q ? DUMMY : WDATA;
          if (is_rd_q) begin
            mem_rd_d = 1'b1;
            mem_addr_d = addr_w;
            addr_d = addr_w + 24'd1;
          end
        end
      end
      DUMMY: if (rise) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(DUMMY_CYCLES - 1)) state_d = RDATA;
      end
      RDATA: if (fall) begin
        io_d = hi_q ? rdata_q[7:4] : rdata_q[3:0];
        hi_d = ~hi_q;
        if (!hi_q) begin
          mem_rd_d = 1'b1;
          mem_addr_d = addr_q;
          addr_d = addr_q + 24'd1;
        end
      end
      WDATA: if (rise) begin
        hi_d = ~hi_q;
        if (hi_q) wbuf_d = io_s;
        else begin
          mem_wr_d = 1'b1;
          mem_wdata_d = {wbuf_q, io_s};
          mem_addr_d = addr_q;
          addr_d = addr_q + 24'd1;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      csn_sync_q <= '1;
      clk_sync_q <= '0;
      vld_q <= '0;
      io_sync_q <= '{default: 4'h0};
      csn_prev_q <= 1'b0;
      clk_prev_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= 4'd0;
      cmd_q <= 4'd0;
      addr_q <= 24'd0;
      is_rd_q <= 1'b0;
      hi_q <= 1'b1;
      wbuf_q <= 4'd0;
      io_q <= 4'd0;
      mem_addr_q <= 24'd0;
      mem_wdata_q <= 8'd0;
      mem_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      rd_dly_q <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      csn_sync_q <= csn_sync_d;
      clk_sync_q <= clk_sync_d;
      vld_q <= vld_d;
      io_sync_q <= io_sync_d;
      csn_prev_q <= csn_prev_d;
      clk_prev_q <= clk_prev_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      is_rd_q <= is_rd_d;
      hi_q <= hi_d;
      wbuf_q <= wbuf_d;
      io_q <= io_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q <= mem_wr_d;
      mem_rd_q <= mem_rd_d;
      rd_dly_q <= rd_dly_d;
      rdata_q <= rdata_d;
    end
  end
endmodule
